// File: rtl/mips_imem_loader.sv
// mips_imem_loader
// Host-side writer for the MIPS instruction memory. Receives a byte stream
// (16-bit word count, MSB first, then 4 bytes per word, MSB first), writes
// each assembled word to consecutive word addresses from 0, and holds the
// core frozen until the whole program has landed.
//
// Optional build feature:
//   LOADER_CHECKSUM_EN - the stream carries one trailing byte that must equal
//                        the XOR of every data byte; a mismatch ends in ERR.
//                        With the macro undefined there is no checksum byte.
module mips_imem_loader #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [7:0]            byte_in,
    input  logic                  byte_valid,
    output logic                  byte_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  core_hold,
    output logic                  done,
    output logic                  error
);

    // Word counter is one bit wider than the 16-bit length so that a full
    // memory of 2**16 words can still be counted without overflow.
    localparam int                 CNT_W = 17;
    localparam logic [CNT_W-1:0]   DEPTH = CNT_W'(2 ** ADDR_WIDTH);

    // S_CHECK is only reachable when the checksum feature is compiled in.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_HI = 3'd1,
        S_LEN_LO = 3'd2,
        S_DATA   = 3'd3,
        S_WRITE  = 3'd4,
        S_DONE   = 3'd5,
        S_ERR    = 3'd6,
        S_CHECK  = 3'd7
    } state_t;

    state_t                 state_q,    state_d;
    logic [15:0]            len_q,      len_d;
    logic [CNT_W-1:0]       word_cnt_q, word_cnt_d;
    logic [1:0]             byte_idx_q, byte_idx_d;
    logic [31:0]            word_q,     word_d;
    logic [ADDR_WIDTH-1:0]  addr_q,     addr_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]             xor_q,      xor_d;
`endif

    logic                   xfer;
    logic [CNT_W-1:0]       len_full;
    logic [CNT_W-1:0]       word_cnt_inc;

    // Ready is a pure function of state so it never loops back through
    // byte_valid on the host side.
    always_comb begin
        byte_ready = 1'b0;
        case (state_q)
            S_LEN_HI, S_LEN_LO, S_DATA: byte_ready = 1'b1;
`ifdef LOADER_CHECKSUM_EN
            S_CHECK:                    byte_ready = 1'b1;
`endif
            default:                    byte_ready = 1'b0;
        endcase
    end

    assign xfer         = byte_valid && byte_ready;
    // Complete word count as it stands on the LEN_LO transfer.
    assign len_full     = {1'b0, len_q[15:8], byte_in};
    assign word_cnt_inc = word_cnt_q + CNT_W'(1);

    // Next-state logic: stream parsing, word assembly and write sequencing.
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        word_cnt_d = word_cnt_q;
        byte_idx_d = byte_idx_q;
        word_d     = word_q;
        addr_d     = addr_q;
`ifdef LOADER_CHECKSUM_EN
        xor_d      = xor_q;
`endif
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d = S_LEN_HI;
`ifdef LOADER_CHECKSUM_EN
                    xor_d   = 8'h00;
`endif
                end
            end
            S_LEN_HI: begin
                if (xfer) begin
                    len_d[15:8] = byte_in;
                    state_d     = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (xfer) begin
                    len_d[7:0] = byte_in;
                    if (len_full == '0) begin
`ifdef LOADER_CHECKSUM_EN
                        state_d = S_CHECK;
`else
                        state_d = S_DONE;
`endif
                    end else if (len_full > DEPTH) begin
                        state_d = S_ERR;
                    end else begin
                        state_d    = S_DATA;
                        word_cnt_d = '0;
                        byte_idx_d = 2'd0;
                    end
                end
            end
            S_DATA: begin
                if (xfer) begin
                    word_d     = {word_q[23:0], byte_in};
                    byte_idx_d = byte_idx_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                    xor_d      = xor_q ^ byte_in;
`endif
                    if (byte_idx_q == 2'd3) begin
                        state_d = S_WRITE;
                        // Latch the address here so it stays put after the
                        // write while the counter moves on.
                        addr_d  = word_cnt_q[ADDR_WIDTH-1:0];
                    end
                end
            end
            S_WRITE: begin
                word_cnt_d = word_cnt_inc;
                if (word_cnt_inc == {1'b0, len_q}) begin
`ifdef LOADER_CHECKSUM_EN
                    state_d = S_CHECK;
`else
                    state_d = S_DONE;
`endif
                end else begin
                    state_d = S_DATA;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHECK: begin
                if (xfer) begin
                    state_d = (byte_in == xor_q) ? S_DONE : S_ERR;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset has priority over any start.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            word_cnt_q <= '0;
            byte_idx_q <= '0;
            word_q     <= '0;
            addr_q     <= '0;
`ifdef LOADER_CHECKSUM_EN
            xor_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            word_cnt_q <= word_cnt_d;
            byte_idx_q <= byte_idx_d;
            word_q     <= word_d;
            addr_q     <= addr_d;
`ifdef LOADER_CHECKSUM_EN
            xor_q      <= xor_d;
`endif
        end
    end

    // Status and memory-port outputs decoded from the registered state.
    always_comb begin
        imem_we    = (state_q == S_WRITE);
        imem_addr  = addr_q;
        imem_wdata = word_q;
        core_hold  = (state_q != S_DONE);
        done       = (state_q == S_DONE);
        error      = (state_q == S_ERR);
    end

endmodule

// File: tb/tb_mips_imem_loader.sv
// Self-checking bench for mips_imem_loader: a per-cycle vector table for the
// basic two-word load, then hand-written sequences for gaps, empty loads,
// oversize/full-depth loads, mid-load reset and (when built in) checksums.
module tb_mips_imem_loader;

    localparam int AW = 8;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic [7:0]    byte_in;
    logic          byte_valid;
    logic          byte_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          core_hold;
    logic          done;
    logic          error;

    mips_imem_loader #(.ADDR_WIDTH(AW)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_hold  (core_hold),
        .done       (done),
        .error      (error)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic          st;
        logic          bv;
        logic [7:0]    b;
        logic          br;
        logic          we;
        logic [AW-1:0] addr;
        logic [31:0]   wd;
        logic          cwd;
        logic          hold;
        logic          dn;
        logic          er;
    } vec_t;

    vec_t          tv[$];
    logic [7:0]    strm[$];
    logic [AW-1:0] wa_q[$];
    logic [31:0]   wd_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Write monitor: records every write, and byte_ready must be low then.
    always @(negedge clock) begin
        if (imem_we === 1'b1) begin
            wa_q.push_back(imem_addr);
            wd_q.push_back(imem_wdata);
            checks++;
            if (byte_ready !== 1'b0) begin
                errors++;
                $display("FAIL write_ready: got byte_ready=%b expected 0 at addr %h", byte_ready, imem_addr);
            end
            $display("write addr=%h data=%h", imem_addr, imem_wdata);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic addv(input logic st, input logic bv, input logic [7:0] b,
                        input logic br, input logic we, input logic [AW-1:0] addr,
                        input logic [31:0] wd, input logic cwd,
                        input logic hold, input logic dn, input logic er);
        vec_t v;
        v.st = st; v.bv = bv; v.b = b; v.br = br; v.we = we; v.addr = addr;
        v.wd = wd; v.cwd = cwd; v.hold = hold; v.dn = dn; v.er = er;
        tv.push_back(v);
    endtask

    // Offer one byte, holding valid until it is accepted. Called and
    // returns just after a falling edge.
    task automatic send_byte(input logic [7:0] b);
        int   n = 0;
        logic rdy;
        byte_in    = b;
        byte_valid = 1'b1;
        forever begin
            rdy = byte_ready;
            @(negedge clock);
            if (rdy) break;
            n++;
            if (n > 40) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: byte %h not accepted after %0d cycles", b, n);
                break;
            end
        end
        byte_valid = 1'b0;
    endtask

    task automatic idle(input int k);
        byte_valid = 1'b0;
        repeat (k) @(negedge clock);
    endtask

    task automatic pulse_start();
        start      = 1'b1;
        byte_valid = 1'b0;
        @(negedge clock);
        start = 1'b0;
    endtask

    // Sends strm; optional random gaps; a start pulse before byte mid_start.
    task automatic send_stream(input int gap_max, input int mid_start);
        for (int i = 0; i < strm.size(); i++) begin
            if (i == mid_start) pulse_start();
            send_byte(strm[i]);
            if (gap_max > 0 && $urandom_range(0, 3) == 0) idle($urandom_range(1, gap_max));
        end
        byte_valid = 1'b0;
    endtask

    task automatic wait_end(input string name);
        int n = 0;
        while (!(done === 1'b1 || error === 1'b1) && n < 3000) begin
            @(negedge clock);
            n++;
        end
        if (n >= 3000) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: done/error not seen within %0d cycles", name, n);
        end
    endtask

    // Length header, n words of data from a simple pattern, optional checksum.
    task automatic build(input int n, input int seed);
        logic [7:0] x = 8'h00;
        logic [7:0] b;
        strm = {};
        strm.push_back(8'((n >> 8) & 255));
        strm.push_back(8'(n & 255));
        for (int i = 0; i < 4 * n; i++) begin
            b = 8'((i * seed + 3) & 255);
            x = x ^ b;
            strm.push_back(b);
        end
`ifdef LOADER_CHECKSUM_EN
        strm.push_back(x);
`endif
    endtask

    // Compare captured writes against the words carried by strm.
    task automatic check_writes(input string name);
        int         n;
        int         bad = 0;
        logic [31:0] w;
        n = {strm[0], strm[1]};
        chk({name, ".count"}, wa_q.size(), n);
        for (int i = 0; i < n && i < wa_q.size(); i++) begin
            w = {strm[2 + 4 * i], strm[3 + 4 * i], strm[4 + 4 * i], strm[5 + 4 * i]};
            if (wa_q[i] !== AW'(i) || wd_q[i] !== w) bad++;
        end
        chk({name, ".bad_words"}, bad, 0);
    endtask

    task automatic clear_writes();
        wa_q = {};
        wd_q = {};
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_in = 8'h00;

        // Basic two-word load, one row per cycle: expected outputs are those
        // seen before the row's inputs are applied.
        //   st bv byte   br we addr   wdata          cwd hold done err
        addv(1, 0, 8'h00, 0, 0, 8'h00, 32'h0000_0000, 1, 1, 0, 0); // IDLE after reset
        addv(0, 1, 8'h00, 1, 0, 8'h00, 32'h0,         0, 1, 0, 0); // LEN_HI
        addv(0, 1, 8'h02, 1, 0, 8'h00, 32'h0,         0, 1, 0, 0); // LEN_LO
        addv(0, 1, 8'h20, 1, 0, 8'h00, 32'h0,         0, 1, 0, 0);
        addv(0, 1, 8'h08, 1, 0, 8'h00, 32'h0,         0, 1, 0, 0);
        addv(0, 1, 8'h00, 1, 0, 8'h00, 32'h0,         0, 1, 0, 0);
        addv(0, 1, 8'h05, 1, 0, 8'h00, 32'h0,         0, 1, 0, 0);
        addv(0, 1, 8'h01, 0, 1, 8'h00, 32'h2008_0005, 1, 1, 0, 0); // WRITE, byte not taken
        addv(0, 1, 8'h01, 1, 0, 8'h00, 32'h0,         0, 1, 0, 0); // byte re-offered
        addv(0, 1, 8'h09, 1, 0, 8'h00, 32'h0,         0, 1, 0, 0);
        addv(0, 1, 8'h50, 1, 0, 8'h00, 32'h0,         0, 1, 0, 0);
        addv(0, 1, 8'h20, 1, 0, 8'h00, 32'h0,         0, 1, 0, 0);
        addv(0, 0, 8'h00, 0, 1, 8'h01, 32'h0109_5020, 1, 1, 0, 0); // WRITE addr 1
`ifdef LOADER_CHECKSUM_EN
        addv(0, 1, 8'h55, 1, 0, 8'h01, 32'h0,         0, 1, 0, 0); // CHECK, xor=55
`endif
        addv(0, 0, 8'h00, 0, 0, 8'h01, 32'h0,         0, 0, 1, 0); // DONE, addr held

        repeat (3) @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < tv.size(); i++) begin
            chk($sformatf("v%0d.byte_ready", i), byte_ready, tv[i].br);
            chk($sformatf("v%0d.imem_we", i), imem_we, tv[i].we);
            chk($sformatf("v%0d.imem_addr", i), imem_addr, tv[i].addr);
            if (tv[i].cwd) chk($sformatf("v%0d.imem_wdata", i), imem_wdata, tv[i].wd);
            chk($sformatf("v%0d.core_hold", i), core_hold, tv[i].hold);
            chk($sformatf("v%0d.done", i), done, tv[i].dn);
            chk($sformatf("v%0d.error", i), error, tv[i].er);
            $display("vector %0d: st=%b bv=%b byte=%h br=%b we=%b addr=%h wd=%h hold=%b done=%b err=%b",
                     i, tv[i].st, tv[i].bv, tv[i].b, byte_ready, imem_we, imem_addr, imem_wdata,
                     core_hold, done, error);
            start      = tv[i].st;
            byte_valid = tv[i].bv;
            byte_in    = tv[i].b;
            @(negedge clock);
        end
        start = 1'b0; byte_valid = 1'b0;

        // Gaps with valid held through WRITE; a stray start mid-DATA is ignored.
        clear_writes();
        build(3, 13);
        pulse_start();
        send_stream(3, 6);
        wait_end("gaps");
        chk("gaps.done", done, 1'b1);
        chk("gaps.error", error, 1'b0);
        check_writes("gaps");

        // Empty program: no writes, straight to DONE.
        clear_writes();
        build(0, 1);
        pulse_start();
        send_stream(0, -1);
        wait_end("empty");
        chk("empty.done", done, 1'b1);
        chk("empty.writes", wa_q.size(), 0);

        // Oversize length 257 for a 256-word memory.
        clear_writes();
        strm = {8'h01, 8'h01};
        pulse_start();
        send_stream(0, -1);
        wait_end("oversize");
        chk("oversize.error", error, 1'b1);
        chk("oversize.done", done, 1'b0);
        chk("oversize.core_hold", core_hold, 1'b1);
        chk("oversize.byte_ready", byte_ready, 1'b0);
        chk("oversize.writes", wa_q.size(), 0);

        // Full depth: 256 words, last at address FF, error cleared by start.
        build(256, 7);
        pulse_start();
        chk("full.error_cleared", error, 1'b0);
        send_stream(0, -1);
        wait_end("full");
        chk("full.done", done, 1'b1);
        check_writes("full");
        chk("full.last_addr", (wa_q.size() > 0) ? 32'(wa_q[wa_q.size() - 1]) : 32'hFFFF_FFFF, 32'h0000_00FF);

        // Reset after 6 data bytes, with start in the same cycle (reset wins).
        clear_writes();
        build(2, 5);
        pulse_start();
        for (int i = 0; i < 8; i++) send_byte(strm[i]);
        reset = 1'b1; start = 1'b1;
        @(negedge clock);
        reset = 1'b0; start = 1'b0;
        chk("rst.byte_ready", byte_ready, 1'b0);
        chk("rst.imem_we", imem_we, 1'b0);
        chk("rst.imem_addr", imem_addr, 8'h00);
        chk("rst.imem_wdata", imem_wdata, 32'h0);
        chk("rst.core_hold", core_hold, 1'b1);
        chk("rst.done", done, 1'b0);
        chk("rst.error", error, 1'b0);
        idle(2);
        chk("rst.idle_ready", byte_ready, 1'b0);
        clear_writes();
        build(2, 11);
        pulse_start();
        send_stream(2, -1);
        wait_end("reload");
        chk("reload.done", done, 1'b1);
        check_writes("reload");

`ifdef LOADER_CHECKSUM_EN
        // Good and bad checksum for one word AA550FF0 (xor of its bytes = 00).
        clear_writes();
        strm = {8'h00, 8'h01, 8'hAA, 8'h55, 8'h0F, 8'hF0, 8'h00};
        pulse_start();
        send_stream(0, -1);
        wait_end("csum_ok");
        chk("csum_ok.done", done, 1'b1);
        chk("csum_ok.error", error, 1'b0);
        check_writes("csum_ok");
        clear_writes();
        strm = {8'h00, 8'h01, 8'hAA, 8'h55, 8'h0F, 8'hF0, 8'h01};
        pulse_start();
        send_stream(0, -1);
        wait_end("csum_bad");
        chk("csum_bad.error", error, 1'b1);
        chk("csum_bad.done", done, 1'b0);
        check_writes("csum_bad");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
